dtcm_lsu: RTL

Memory-stage load/store unit between the MEM-stage control and the single-port DTCM SRAM.
- Accepts one access per handshake and generates SRAM chip-select, write-enable, byte-enables and lane-replicated write data.
- Waits a fixed SRAM read latency, then returns load data right-aligned to bit 0. The downstream load sign/zero-extension stage consumes this value as its DTCM input.
- Stalls the pipeline while busy and flags misaligned or illegal accesses.

---
 rtl/dtcm_lsu_pkg.sv | 18 +
 rtl/dtcm_store_align.sv | 39 +++
 rtl/dtcm_lsu.sv | 120 ++++++++++++
 3 files changed

// File: rtl/dtcm_lsu_pkg.sv
// dtcm_lsu shared definitions
// access size codes and LSU state encodings
package dtcm_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int UNSIGNED_BIT = 2;

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/dtcm_store_align.sv
// dtcm_store_align: store lane steering
// byte enables, replicated data, misalignment
module dtcm_store_align
  import dtcm_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misaligned
);

  // lane enables and data replication by size
  always_comb begin
    be         = 4'b0000;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    unique case (1'b1)
      size == SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      size == SZ_HALF: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      size == SZ_WORD: begin
        be         = 4'b1111;
        misaligned = |addr_lo;
      end
      default: begin
        be = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dtcm_lsu.sv
// dtcm_lsu: MEM-stage load/store unit
// drives the single-port DTCM SRAM
module dtcm_lsu
  import dtcm_lsu_pkg::*;
#(
  parameter int AW     = 12,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          ctrl_mem_read,
  input  logic          ctrl_mem_write,
  input  logic [2:0]    RW_type,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [31:0]   dtcm_datain,
  output logic          stall,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [3:0]    ram_be,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

  lsu_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       lo_q;
  logic             err_q;
  logic             accept;
  logic             illegal;
  logic             misaligned;
  logic             legal;
  logic             is_load;
  logic [3:0]       be_raw;
  logic             unused_ok;

  dtcm_store_align u_align (
    .size       (RW_type[1:0]),
    .addr_lo    (addr[1:0]),
    .wdata      (wdata),
    .be         (be_raw),
    .wdata_rep  (ram_wdata),
    .misaligned (misaligned)
  );

  // the load/unsigned flag is consumed downstream
  assign unused_ok = ^{RW_type[UNSIGNED_BIT], addr[31:AW+2]};

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready && rst_n;
  assign illegal   = (RW_type[1:0] == 2'b11) ||
                     (ctrl_mem_read == ctrl_mem_write);
  assign legal     = !illegal && !misaligned;
  assign is_load   = legal && ctrl_mem_read;

  assign ram_cs    = accept && legal;
  assign ram_we    = ram_cs && ctrl_mem_write;
  assign ram_be    = ram_we ? be_raw : 4'b0000;
  assign ram_addr  = addr[AW+1:2];

  assign stall     = rst_n &&
                     ((req_valid && state == IDLE) ||
                      state == RD_WAIT);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid && err_q;

  // next state and read-latency countdown
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = is_load ? RD_WAIT : RESP;
          if (is_load) cnt_nx = CNT_INIT;
        end
      end
      RD_WAIT: begin
        if (cnt == '0) state_nx = RESP;
        else           cnt_nx   = cnt - 1'b1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state, counter and accepted-access registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      lo_q  <= 2'b00;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        lo_q  <= addr[1:0];
        err_q <= !legal;
      end
    end
  end

  // capture right-aligned load data at end of wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dtcm_datain <= '0;
    end else if (state == RD_WAIT && cnt == '0) begin
      dtcm_datain <= ram_rdata >> {lo_q, 3'b000};
    end
  end

endmodule
